// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit: forwarding codes, drain FSM states, scoreboard entry.
// No logic; latency and backpressure are defined by the modules that import it.
// rd is stored at RD_W bits so one entry type serves every REG_AW up to RD_W.
package pipe_pkg;

    localparam int FWD_RF = 0;
    localparam int RD_W   = 8;

    typedef logic [1:0] hz_state_t;
    localparam hz_state_t RUN   = 2'd0;
    localparam hz_state_t DRAIN = 2'd1;
    localparam hz_state_t IDLE  = 2'd2;

    typedef struct packed {
        logic            valid;
        logic            wr;
        logic            load;
        logic [RD_W-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_unit_match.sv
// Matches one source register against the scoreboard; youngest writer wins.
// Latency: combinational. Backpressure: none, pure lookup.
// load_hit flags a load sitting in slot 1 that this source depends on.
import pipe_pkg::*;

module hz_match #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int FSEL_W = 2
) (
    input  logic [REG_AW-1:0]     src,
    input  sb_entry_t [DEPTH:1]   sb,
    output logic [FSEL_W-1:0]     fsel,
    output logic                  load_hit
);

    logic sel_load;

    // Walk oldest to youngest so the last hit taken is the youngest.
    always_comb begin
        fsel     = FSEL_W'(FWD_RF);
        sel_load = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (sb[k].valid && sb[k].wr && (sb[k].rd == RD_W'(src)) && (src != '0)) begin
                fsel     = FSEL_W'(k);
                sel_load = sb[k].load;
            end
        end
        load_hit = (fsel == FSEL_W'(1)) && sel_load;
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based forwarding, load-use stall, late-redirect flush and drain handshake; HAZ_PERF_EN adds perf counters.
// Latency: fwd/stall/flush/kill combinational same cycle; scoreboard, FSM and counters update on clk.
// Backpressure: stall holds PC and IF/ID (load-use, or whenever not in RUN); redirect overrides a load-use stall.
import pipe_pkg::*;

module pipe_hazard_unit #(
`ifdef HAZ_PERF_EN
    parameter int CNT_W      = 32,
`endif
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int REDIR_SLOT = 2,
    parameter int FSEL_W     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               id_wr,
    input  logic               id_load,
    input  logic               redirect,
    input  logic               drain_req,
    output logic [FSEL_W-1:0]  fwd_a,
    output logic [FSEL_W-1:0]  fwd_b,
    output logic               stall,
    output logic               flush_if,
    output logic               flush_id,
    output logic [DEPTH-1:0]   slot_kill,
`ifdef HAZ_PERF_EN
    output logic               drain_done,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`else
    output logic               drain_done
`endif
);

    hz_state_t            state_q, state_d;
    sb_entry_t [DEPTH:1]  sb_q, sb_d;
    sb_entry_t            id_entry;
    logic                 hit_a, hit_b, lu_stall, admit, all_empty;

    hz_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FSEL_W(FSEL_W)) u_match_a (
        .src(id_rs), .sb(sb_q), .fsel(fwd_a), .load_hit(hit_a)
    );
    hz_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FSEL_W(FSEL_W)) u_match_b (
        .src(id_rt), .sb(sb_q), .fsel(fwd_b), .load_hit(hit_b)
    );

    // Outside RUN the pipe is quiescing, so decode is held rather than admitted.
    assign lu_stall   = id_valid & (hit_a | hit_b) & ~redirect & (state_q == RUN);
    assign stall      = lu_stall | (state_q != RUN);
    assign flush_if   = redirect;
    assign flush_id   = redirect;
    assign drain_done = (state_q == IDLE);
    assign admit      = id_valid & ~stall & ~redirect;

    always_comb begin
        id_entry       = '0;
        id_entry.valid = 1'b1;
        id_entry.wr    = id_wr;
        id_entry.load  = id_load;
        id_entry.rd    = RD_W'(id_rd);
    end

    always_comb begin
        slot_kill = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (k < REDIR_SLOT) slot_kill[k-1] = redirect;
        end
    end

    always_comb begin
        all_empty = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            if (sb_q[k].valid) all_empty = 1'b0;
        end
    end

    // Slots younger than the redirecting one are wrong-path and die as they shift.
    always_comb begin
        sb_d    = '0;
        sb_d[1] = admit ? id_entry : '0;
        for (int k = 2; k <= DEPTH; k++) begin
            sb_d[k] = (redirect && (k <= REDIR_SLOT)) ? '0 : sb_q[k-1];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_req) state_d = DRAIN;
            DRAIN:   if (!drain_req) state_d = RUN;
                     else if (all_empty) state_d = IDLE;
            IDLE:    if (!drain_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q    <= '0;
            state_q <= RUN;
        end else begin
            sb_q    <= sb_d;
            state_q <= state_d;
        end
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (lu_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed table of per-cycle decode inputs with hand-computed outputs, plus reset-mid-drain and counter sequences.
module tb_pipe_hazard_unit;

    localparam int DEPTH  = 3;
    localparam int FSEL_W = 2;
    localparam int NV     = 28;
`ifdef HAZ_PERF_EN
    localparam int CNT_W  = 4;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid, id_wr, id_load, redirect, drain_req;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic [FSEL_W-1:0] fwd_a, fwd_b;
    logic              stall, flush_if, flush_id, drain_done;
    logic [DEPTH-1:0]  slot_kill;
`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(
`ifdef HAZ_PERF_EN
        .CNT_W(CNT_W),
`endif
        .REG_AW(5), .DEPTH(DEPTH), .REDIR_SLOT(2), .FSEL_W(FSEL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .redirect(redirect),
        .drain_req(drain_req), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
        .flush_if(flush_if), .flush_id(flush_id), .slot_kill(slot_kill),
`ifdef HAZ_PERF_EN
        .drain_done(drain_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
        .drain_done(drain_done)
`endif
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs, rt, rd;
        logic       wr, ld, redir, drain;
        logic       chk;
        logic [1:0] fa, fb;
        logic       st, fl;
        logic [2:0] kill;
        logic       done;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mkv(input int v, rs, rt, rd, wr, ld, redir, drain,
                                 input int chk, fa, fb, st, fl, kill, done);
        vec_t r;
        r.v = 1'(v);   r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
        r.wr = 1'(wr); r.ld = 1'(ld); r.redir = 1'(redir); r.drain = 1'(drain);
        r.chk = 1'(chk); r.fa = 2'(fa); r.fb = 2'(fb); r.st = 1'(st);
        r.fl = 1'(fl); r.kill = 3'(kill); r.done = 1'(done);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_rd = t.rd;
        id_wr = t.wr; id_load = t.ld; redirect = t.redir; drain_req = t.drain;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " fwd_a"}, int'(fwd_a), 0);
        check({tag, " fwd_b"}, int'(fwd_b), 0);
        check({tag, " stall"}, int'(stall), 0);
        check({tag, " flush_if"}, int'(flush_if), 0);
        check({tag, " flush_id"}, int'(flush_id), 0);
        check({tag, " slot_kill"}, int'(slot_kill), 0);
        check({tag, " drain_done"}, int'(drain_done), 0);
`ifdef HAZ_PERF_EN
        check({tag, " stall_cnt"}, int'(stall_cnt), 0);
        check({tag, " flush_cnt"}, int'(flush_cnt), 0);
`endif
    endtask

    initial begin
        //              v rs rt rd wr ld rd dr  chk fa fb st fl kill done
        tbl[0]  = mkv(1, 1, 2, 3, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // add r3
        tbl[1]  = mkv(1, 3, 4, 6, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0); // sub reads r3 from EX
        tbl[2]  = mkv(1, 0, 3, 7, 1, 0, 0, 0,  1, 0, 2, 0, 0, 0, 0); // r3 now in MEM
        tbl[3]  = mkv(1, 1, 0, 5, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0); // lw r5
        tbl[4]  = mkv(1, 2, 5, 8, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0); // load-use stall
        tbl[5]  = mkv(1, 2, 5, 8, 1, 0, 0, 0,  1, 0, 2, 0, 0, 0, 0); // after bubble, fwd 2
        tbl[6]  = mkv(1, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // writes r0
        tbl[7]  = mkv(1, 0, 0, 8, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // reads r0 behind r0 writer
        tbl[8]  = mkv(1, 8, 8,10, 1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0); // youngest r8 wins
        tbl[9]  = mkv(0,10, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0); // no decode
        tbl[10] = mkv(1,10, 0,11, 1, 1, 0, 0,  1, 2, 0, 0, 0, 0, 0); // lw r11
        tbl[11] = mkv(0,11, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0); // load hit without valid
        tbl[12] = mkv(1, 0, 0,14, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // add r14
        tbl[13] = mkv(1, 0, 0,12, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0); // lw r12
        tbl[14] = mkv(1, 0,12,13, 1, 0, 1, 0,  1, 0, 1, 0, 1, 1, 0); // redirect beats stall
        tbl[15] = mkv(1,14,12,15, 1, 0, 0, 0,  1, 3, 0, 0, 0, 0, 0); // r14 kept, r12 killed
        tbl[16] = mkv(1, 0, 0,16, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        tbl[17] = mkv(1, 0, 0,17, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        tbl[18] = mkv(0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0); // drain_req rises, 3 slots valid
        tbl[19] = mkv(1, 0, 0,19, 1, 0, 0, 1,  0, 0, 0, 1, 0, 0, 0);
        tbl[20] = mkv(1,19,17, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 0);
        tbl[21] = mkv(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 0);
        tbl[22] = mkv(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 1); // 4 cycles after request
        tbl[23] = mkv(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1);
        tbl[24] = mkv(1, 0, 0,20, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // back in RUN
        tbl[25] = mkv(1, 0, 0,21, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
        tbl[26] = mkv(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0); // abort drain
        tbl[27] = mkv(1, 0, 0,22, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // RUN, no done pulse

        rst_n = 1'b0;
        drive(mkv(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        repeat (2) @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            if (tbl[i].chk) begin
                check($sformatf("v%0d fwd_a", i), int'(fwd_a), int'(tbl[i].fa));
                check($sformatf("v%0d fwd_b", i), int'(fwd_b), int'(tbl[i].fb));
            end
            check($sformatf("v%0d stall", i), int'(stall), int'(tbl[i].st));
            check($sformatf("v%0d flush_if", i), int'(flush_if), int'(tbl[i].fl));
            check($sformatf("v%0d flush_id", i), int'(flush_id), int'(tbl[i].fl));
            check($sformatf("v%0d slot_kill", i), int'(slot_kill), int'(tbl[i].kill));
            check($sformatf("v%0d drain_done", i), int'(drain_done), int'(tbl[i].done));
            @(posedge clk); #1;
        end

        // Reset in the middle of a drain with work in flight.
        drive(mkv(1,0,0,23,1,0,0,1, 0,0,0,0,0,0,0));
        @(posedge clk); #1;
        drive(mkv(0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
        @(negedge clk);
        check("middrain stall", int'(stall), 1);
        #2;
        rst_n = 1'b0;
        drive(mkv(1,23,23,0,0,0,0,1, 0,0,0,0,0,0,0));
        #1;
        check_quiet("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst run stall", int'(stall), 0);
        check("post_rst fwd_a", int'(fwd_a), 0);
        check("post_rst drain_done", int'(drain_done), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst drain stall", int'(stall), 1);
        @(posedge clk); #1;
        drive(mkv(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        @(posedge clk); #1;

`ifdef HAZ_PERF_EN
        for (int i = 0; i < 20; i++) begin
            drive(mkv(1,0,0,5,1,1,0,0, 0,0,0,0,0,0,0));
            @(posedge clk); #1;
            drive(mkv(1,0,5,6,1,0,0,0, 0,0,0,0,0,0,0));
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        drive(mkv(0,0,0,0,0,0,1,0, 0,0,0,0,0,0,0));
        repeat (3) begin
            @(posedge clk); #1;
        end
        drive(mkv(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        @(negedge clk);
        check("stall_cnt saturated", int'(stall_cnt), 15);
        check("flush_cnt", int'(flush_cnt), 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
